bw_clk_cl_hdr_seq: RTL and testbench

BW_CLK_CL_HDR_SEQ -- requirements
Module: bw_clk_cl_hdr_seq

---
 rtl/bw_clk_cl_hdr_seq.sv | 211 +++++++++++++++++++++
 tb/tb_bw_clk_cl_hdr_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bw_clk_cl_hdr_seq.sv
// -----------------------------------------------------------------------------
// bw_clk_cl_hdr_seq
//
// Cluster clock-header sequencer. Synchronizes the global reset and debug-init
// requests into the gclk domain, then releases per-cluster clock enables one at
// a time, STAGGER gclk cycles apart, before lifting the per-cluster resets
// together. Once running, cluster enables follow cken_req with one cycle of
// latency. The cluster enable register doubles as a scan chain.
//
// Parameters
//   NUM_CL   : number of cluster headers (1..16)
//   SYNC_STG : synchronizer depth for grst_l / gdbginit_l (2..4)
//   STAGGER  : gclk cycles between successive enable releases (1..15)
//
// Ports
//   gclk           in   clock, all flops rising-edge
//   arst_l         in   asynchronous active-low reset
//   grst_l         in   global reset request, active-low, async to gclk
//   gdbginit_l     in   global debug-init request, active-low, async to gclk
//   cken_req       in   per-cluster clock-enable request
//   se, si         in   scan enable / scan in
//   cluster_cken   out  registered per-cluster clock enables
//   cluster_grst_l out  registered per-cluster resets, active-low
//   dbginit_l      out  registered synchronized debug init (0 unless RUN)
//   seq_busy       out  registered, high while ramping
//   so             out  scan out (top bit of the cluster enable register)
// -----------------------------------------------------------------------------
module bw_clk_cl_hdr_seq #(
    parameter int NUM_CL   = 4,
    parameter int SYNC_STG = 3,
    parameter int STAGGER  = 2
) (
    input  logic              gclk,
    input  logic              arst_l,
    input  logic              grst_l,
    input  logic              gdbginit_l,
    input  logic [NUM_CL-1:0] cken_req,
    input  logic              se,
    input  logic              si,
    output logic [NUM_CL-1:0] cluster_cken,
    output logic [NUM_CL-1:0] cluster_grst_l,
    output logic              dbginit_l,
    output logic              seq_busy,
    output logic              so
);

    localparam int                IDX_W    = (NUM_CL > 1) ? $clog2(NUM_CL) : 1;
    localparam logic [3:0]        CNT_LAST = 4'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CL - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } state_e;

    logic [SYNC_STG-1:0] grst_sync_q;
    logic [SYNC_STG-1:0] dbg_sync_q;
    logic                grst_s;
    logic                dbg_s;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    // Set on the edge that releases the last cluster; RUN follows one edge later.
    logic                last_q, last_d;
    logic [NUM_CL-1:0]   cken_q, cken_d;
    logic [NUM_CL-1:0]   grst_q, grst_d;
    logic                dbg_q, dbg_d;
    logic                busy_q, busy_d;
    logic [NUM_CL-1:0]   scan_shift;

    // Synchronizers keep running in scan mode.
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            grst_sync_q <= '0;
            dbg_sync_q  <= '0;
        end else begin
            grst_sync_q <= {grst_sync_q[SYNC_STG-2:0], grst_l};
            dbg_sync_q  <= {dbg_sync_q[SYNC_STG-2:0], gdbginit_l};
        end
    end

    assign grst_s = grst_sync_q[SYNC_STG-1];
    assign dbg_s  = dbg_sync_q[SYNC_STG-1];

    // State register
    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; scan mode freezes the FSM.
    always_comb begin
        state_d = state_q;
        if (!se) begin
            case (state_q)
                HOLD: if (grst_s) state_d = RAMP;
                RAMP: begin
                    if (!grst_s) begin
                        state_d = HOLD;
                    end else if (last_q) begin
                        state_d = RUN;
                    end
                end
                RUN:  if (!grst_s) state_d = HOLD;
                default: state_d = HOLD;
            endcase
        end
    end

    // si enters bit 0, each bit moves one position toward the top.
    always_comb begin
        scan_shift    = '0;
        scan_shift[0] = si;
        for (int i = 1; i < NUM_CL; i++) begin
            scan_shift[i] = cken_q[i-1];
        end
    end

    // Output / datapath next values
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        last_d = last_q;
        cken_d = cken_q;
        grst_d = grst_q;
        if (se) begin
            cken_d = scan_shift;
        end else begin
            case (state_q)
                RAMP: begin
                    if (!grst_s) begin
                        cnt_d  = '0;
                        idx_d  = '0;
                        last_d = 1'b0;
                        cken_d = '0;
                        grst_d = '0;
                    end else if (last_q) begin
                        grst_d = '1;
                    end else if (cnt_q == CNT_LAST) begin
                        // Only the cluster being released samples its request.
                        for (int i = 0; i < NUM_CL; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                cken_d[i] = cken_req[i];
                            end
                        end
                        cnt_d = '0;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            last_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                RUN: begin
                    if (!grst_s) begin
                        cnt_d  = '0;
                        idx_d  = '0;
                        last_d = 1'b0;
                        cken_d = '0;
                        grst_d = '0;
                    end else begin
                        cken_d = cken_req;
                    end
                end
                default: begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    last_d = 1'b0;
                    cken_d = '0;
                    grst_d = '0;
                end
            endcase
        end
        // Derived from the next state so the flags line up with state_q.
        busy_d = (state_d == RAMP);
        dbg_d  = (state_d == RUN) ? dbg_s : 1'b0;
    end

    always_ff @(posedge gclk or negedge arst_l) begin
        if (!arst_l) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            cken_q <= '0;
            grst_q <= '0;
            dbg_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            cken_q <= cken_d;
            grst_q <= grst_d;
            dbg_q  <= dbg_d;
            busy_q <= busy_d;
        end
    end

    assign cluster_cken   = cken_q;
    assign cluster_grst_l = grst_q;
    assign dbginit_l      = dbg_q;
    assign seq_busy       = busy_q;
    assign so             = cken_q[NUM_CL-1];

endmodule

// File: tb/tb_bw_clk_cl_hdr_seq.sv
// -----------------------------------------------------------------------------
// tb_bw_clk_cl_hdr_seq
//
// Directed bench for bw_clk_cl_hdr_seq. Three instances share the global
// request inputs: A uses the defaults, B is NUM_CL=1/STAGGER=1, C is
// NUM_CL=16/STAGGER=15. Release of cluster i is expected at edge
// E(3 + STAGGER*(i+1)) and RUN at E(4 + STAGGER*NUM_CL), where E0 is the first
// edge after grst_l rises.
// -----------------------------------------------------------------------------
module tb_bw_clk_cl_hdr_seq;

    logic        gclk = 1'b0;
    logic        arst_l, grst_l, gdbginit_l, se, si;

    logic [3:0]  req_a, ck_a, gr_a;
    logic        dbg_a, busy_a, so_a;
    logic [0:0]  req_b, ck_b, gr_b;
    logic        dbg_b, busy_b, so_b;
    logic [15:0] req_c, ck_c, gr_c;
    logic        dbg_c, busy_c, so_c;

    int n_run  = 0;
    int n_fail = 0;
    int e      = 0;

    always #5 gclk = ~gclk;

    bw_clk_cl_hdr_seq #(.NUM_CL(4), .SYNC_STG(3), .STAGGER(2)) u_dut_a (
        .gclk(gclk), .arst_l(arst_l), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
        .cken_req(req_a), .se(se), .si(si), .cluster_cken(ck_a),
        .cluster_grst_l(gr_a), .dbginit_l(dbg_a), .seq_busy(busy_a), .so(so_a));

    bw_clk_cl_hdr_seq #(.NUM_CL(1), .SYNC_STG(3), .STAGGER(1)) u_dut_b (
        .gclk(gclk), .arst_l(arst_l), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
        .cken_req(req_b), .se(1'b0), .si(1'b0), .cluster_cken(ck_b),
        .cluster_grst_l(gr_b), .dbginit_l(dbg_b), .seq_busy(busy_b), .so(so_b));

    bw_clk_cl_hdr_seq #(.NUM_CL(16), .SYNC_STG(3), .STAGGER(15)) u_dut_c (
        .gclk(gclk), .arst_l(arst_l), .grst_l(grst_l), .gdbginit_l(gdbginit_l),
        .cken_req(req_c), .se(1'b0), .si(1'b0), .cluster_cken(ck_c),
        .cluster_grst_l(gr_c), .dbginit_l(dbg_c), .seq_busy(busy_c), .so(so_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck(int n, int stg, logic [15:0] req, int ed);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            if (ed >= 3 + stg * (i + 1)) r[i] = req[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge gclk);
        #1;
        e++;
    endtask

    // Check one instance's outputs against the ramp timing model at edge ed.
    task automatic check_seq(input string nm, input int n, input int stg, input logic [15:0] req,
                             input int ed, input logic [15:0] ck, input logic [15:0] gr,
                             input logic busy, input logic dbg, input logic so_v);
        int re;
        logic [15:0] mask;
        logic [15:0] eck;
        re   = 4 + stg * n;
        mask = 16'((32'd1 << n) - 1);
        eck  = exp_ck(n, stg, req, ed);
        check($sformatf("%s cken E%0d", nm, ed), 32'(ck), 32'(eck));
        check($sformatf("%s grst_l E%0d", nm, ed), 32'(gr), (ed >= re) ? 32'(mask) : 32'd0);
        check($sformatf("%s busy E%0d", nm, ed), 32'(busy), 32'(ed >= 3 && ed < re));
        check($sformatf("%s dbginit E%0d", nm, ed), 32'(dbg), 32'(ed >= re));
        check($sformatf("%s so E%0d", nm, ed), 32'(so_v), 32'(eck[n-1]));
    endtask

    task automatic check_a(input int ed);
        check_seq("A", 4, 2, 16'(req_a), ed, 16'(ck_a), 16'(gr_a), busy_a, dbg_a, so_a);
    endtask

    // Reset everything, idle, then raise grst_l so that the next edge is E0.
    task automatic start_ramp(input logic [3:0] ra, input logic [15:0] rc);
        arst_l     = 1'b0;
        grst_l     = 1'b0;
        gdbginit_l = 1'b1;
        se         = 1'b0;
        si         = 1'b0;
        req_a      = ra;
        req_b      = 1'b1;
        req_c      = rc;
        repeat (2) tick();
        arst_l = 1'b1;
        repeat (4) tick();
        grst_l = 1'b1;
        e      = -1;
    endtask

    initial begin
        arst_l     = 1'b1;
        grst_l     = 1'b0;
        gdbginit_l = 1'b1;
        se         = 1'b0;
        si         = 1'b0;
        req_a      = 4'hF;
        req_b      = 1'b1;
        req_c      = 16'hFFFF;

        // Asynchronous reset before any clock edge
        #2 arst_l = 1'b0;
        #1;
        check("rst cken", 32'(ck_a), 32'd0);
        check("rst grst_l", 32'(gr_a), 32'd0);
        check("rst dbginit", 32'(dbg_a), 32'd0);
        check("rst busy", 32'(busy_a), 32'd0);
        check("rst so", 32'(so_a), 32'd0);

        // Full ramp on all three instances
        start_ramp(4'hF, 16'hB7E5);
        for (int k = 0; k <= 246; k++) begin
            tick();
            if (e <= 14) check_a(e);
            if (e <= 7) check_seq("B", 1, 1, 16'(req_b), e, 16'(ck_b), 16'(gr_b), busy_b, dbg_b, so_b);
            check_seq("C", 16, 15, req_c, e, ck_c, gr_c, busy_c, dbg_c, so_c);
        end

        // Partial request pattern, then follow in RUN
        start_ramp(4'b1010, 16'hFFFF);
        for (int k = 0; k <= 12; k++) begin
            tick();
            check_a(e);
        end
        req_a = 4'h5;
        tick();
        check("run follow cken", 32'(ck_a), 32'h5);
        check("run follow grst_l", 32'(gr_a), 32'hF);

        // grst_l dropped mid-ramp
        start_ramp(4'hF, 16'hFFFF);
        for (int k = 0; k <= 7; k++) begin
            tick();
            check_a(e);
        end
        grst_l = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_a(e);
        end
        tick();
        check("drop cken", 32'(ck_a), 32'd0);
        check("drop grst_l", 32'(gr_a), 32'd0);
        check("drop busy", 32'(busy_a), 32'd0);
        tick();
        check("drop hold cken", 32'(ck_a), 32'd0);
        check("drop hold busy", 32'(busy_a), 32'd0);

        // Scan shift in RUN
        start_ramp(4'b1001, 16'hFFFF);
        for (int k = 0; k <= 13; k++) begin
            tick();
            check_a(e);
        end
        se = 1'b1;
        si = 1'b1;
        check("scan so0", 32'(so_a), 32'd1);
        tick();
        check("scan ck1", 32'(ck_a), 32'b0011);
        check("scan so1", 32'(so_a), 32'd0);
        si = 1'b0;
        tick();
        check("scan ck2", 32'(ck_a), 32'b0110);
        check("scan so2", 32'(so_a), 32'd0);
        si = 1'b1;
        tick();
        check("scan ck3", 32'(ck_a), 32'b1101);
        check("scan so3", 32'(so_a), 32'd1);
        si = 1'b1;
        tick();
        check("scan ck4", 32'(ck_a), 32'b1011);
        check("scan busy", 32'(busy_a), 32'd0);
        check("scan grst_l", 32'(gr_a), 32'hF);
        check("scan dbginit", 32'(dbg_a), 32'd1);
        se = 1'b0;
        si = 1'b0;
        tick();
        check("scan exit cken", 32'(ck_a), 32'b1001);
        check("scan exit grst_l", 32'(gr_a), 32'hF);

        // One-cycle debug-init pulse in RUN
        gdbginit_l = 1'b0;
        tick();
        gdbginit_l = 1'b1;
        check("dbg P0", 32'(dbg_a), 32'd1);
        tick();
        check("dbg P1", 32'(dbg_a), 32'd1);
        tick();
        check("dbg P2", 32'(dbg_a), 32'd1);
        tick();
        check("dbg P3", 32'(dbg_a), 32'd0);
        tick();
        check("dbg P4", 32'(dbg_a), 32'd1);

        // Asynchronous reset mid-ramp
        start_ramp(4'hF, 16'hFFFF);
        for (int k = 0; k <= 7; k++) begin
            tick();
            check_a(e);
        end
        #2 arst_l = 1'b0;
        #1;
        check("arst cken", 32'(ck_a), 32'd0);
        check("arst grst_l", 32'(gr_a), 32'd0);
        check("arst busy", 32'(busy_a), 32'd0);
        check("arst dbginit", 32'(dbg_a), 32'd0);
        check("arst so", 32'(so_a), 32'd0);
        #2 arst_l = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("arst rel cken %0d", k), 32'(ck_a), 32'd0);
            check($sformatf("arst rel busy %0d", k), 32'(busy_a), 32'd0);
        end
        tick();
        check("arst re-ramp busy", 32'(busy_a), 32'd1);
        check("arst re-ramp cken", 32'(ck_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
